board_cursor_ctrl: RTL and testbench
====================================

# board_cursor_ctrl

Parametrised front-panel input controller for the chess design. It debounces the five push-buttons and moves a board cursor with wrap or saturate edges and optional auto-repeat. It runs a select/confirm state machine that issues source→destination move requests to the game-logic block over a valid/ready handshake. It sits between the board pins and the chess rules engine, and feeds the cursor and selection coordinates to the VGA renderer.

## Interface
Parameters:
- `BOARD_W`, 8: board columns; 2..64.
- `BOARD_H`, 8: board rows; 2..64.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles before a button level is accepted (10 ms at 25 MHz); ≥2.
- `REPEAT_CYCLES`, 0: auto-repeat period for held direction buttons; 0 disables repeat.
- `WRAP`, 1: 1 = cursor wraps at board edges; 0 = cursor saturates.

Ports (`CW = $clog2(BOARD_W)`, `RW = $clog2(BOARD_H)`):
- `clk` in 1: single clock, 25 MHz.
- `reset` in 1: asynchronous, active-low; all state clears while low.
- `BTNU`, `BTND`, `BTNL`, `BTNR`, `BTNC` in 1 each: raw asynchronous buttons, high = pressed.
- `cur_col` out CW: cursor column.
- `cur_row` out RW: cursor row; row 0 is the bottom.
- `sel_valid` out 1: a source square is selected.
- `sel_col` out CW, `sel_row` out RW: selected source square.
- `move_valid` out 1: move request pending.
- `move_src_col`, `move_dst_col` out CW: move request source and destination columns.
- `move_src_row`, `move_dst_row` out RW: move request source and destination rows.
- `move_ready` in 1: game logic accepts the request when high with `move_valid`.

## Operation
- Per button: 2-flop synchroniser, then debouncer. A counter counts cycles in which the synced level differs from the accepted level; it resets to 0 on any agreement. When the count reaches `DEBOUNCE_CYCLES-1`, the accepted level flips. A press event is a single-cycle pulse on the accepted level's 0→1 transition.
- Auto-repeat (`REPEAT_CYCLES`>0, direction buttons only): while the accepted level is held, a press pulse is regenerated every `REPEAT_CYCLES` cycles after the initial press. BTNC never repeats.
- Cursor: U = row+1, D = row−1, R = col+1, L = col−1.
  - `WRAP`=1: the edge wraps (row `BOARD_H-1`+1 → 0; col 0−1 → `BOARD_W-1`).
  - `WRAP`=0: the cursor holds at the edge.
- Simultaneous direction events in one cycle: only the highest priority is applied, U > D > L > R.
- FSM states:
  - IDLE: BTNC latches `sel` = cursor, sets `sel_valid`, and moves to SELECTED.
  - SELECTED: BTNC with cursor == `sel` clears `sel_valid` and returns to IDLE (cancel). BTNC elsewhere latches dst = cursor, asserts `move_valid`, and moves to REQUEST.
  - REQUEST: all button events are discarded and the cursor is frozen. `move_valid` and all `move_*` fields are held stable until `move_valid && move_ready`. On acceptance the next state is IDLE, with `move_valid`=0 and `sel_valid`=0.
- BTNC and a direction event in the same cycle: BTNC uses the pre-move cursor, and the cursor moves in the same update.
- `move_ready` is ignored outside REQUEST.

## Timing
- Reset values: cursor (0,0); `sel_*`=0; `move_*`=0; state IDLE; debounce counters 0; accepted levels 0.
- Raw button edge (held stable) to cursor/FSM register change: exactly `DEBOUNCE_CYCLES`+3 cycles (2 sync, `DEBOUNCE_CYCLES` debounce, 1 update).
- `move_valid` rises on the cycle after the confirming BTNC press pulse. It falls on the cycle after the handshake cycle. A single-cycle `move_ready` pulse is sufficient.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no event. The counter restarts on every glitch.
- Reset asserted mid-REQUEST drops `move_valid` asynchronously, without a handshake.
- A button held through reset release generates a press only after a full debounce interval.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared `chess_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_SELECTED`, `ST_REQUEST`).
  - Button index constants (`BTN_U`..`BTN_C`) for a 5-bit button vector.
  - The default board dimensions, which the VGA renderer also uses.
- Sub-module `btn_debounce`, parameters `DEBOUNCE_CYCLES` and `REPEAT_CYCLES`: contains the synchroniser, debounce counter, edge detect and repeat timer. It outputs `level` and `press`, and is instantiated ×5.
- The cursor update, FSM and handshake registers stay in `board_cursor_ctrl`.

## Test plan
Unless stated, benches use `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=0, `WRAP`=1, 8×8.
- Press BTNU cleanly for 10 cycles → `cur_row` becomes 1 exactly 7 cycles after the raw edge; there is exactly one step.
- BTNR toggles every 2 cycles for 20 cycles, then holds high → no movement during the bounce; exactly one step after the stable hold.
- Cursor at (0,0), press BTNL then BTND → (7,7). Repeat with `WRAP`=0 → the cursor stays at (0,0).
- Select at (4,1), move the cursor to (4,3), press BTNC with `move_ready` held low for 5 cycles → `move_valid`=1 with src (4,1), dst (4,3) stable all 5 cycles. Directions during this period are ignored. Pulse `move_ready` → `move_valid`=0 and `sel_valid`=0 on the next cycle.
- Select at (2,2), press BTNC again at (2,2) → `sel_valid`=0, state IDLE, `move_valid` never asserted.
- `REPEAT_CYCLES`=10, hold BTNR for 4+3+35 cycles → `cur_col` advances 1, then +1 every 10 cycles, for a total of 4. Assert `reset` low mid-hold → all outputs 0 immediately.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg: shared FSM states, button indices and board dimensions for the chess design
package chess_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SELECTED, ST_REQUEST} state_t;
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;
    localparam int NUM_BTN = 5;
    localparam int BOARD_W_DEF = 8;
    localparam int BOARD_H_DEF = 8;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser, debounce counter, press edge detect and optional auto-repeat
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES = 0
)(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    logic [1:0] sync;
    logic [DW-1:0] cnt;
    logic [PW-1:0] rcnt;
    logic flip, rpt;
    assign flip = (sync[1] != level) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
    // a level flip always wins over a repeat so a release never emits a late pulse
    assign rpt = (REPEAT_CYCLES > 0) && level && !flip && (rcnt == PW'(REPEAT_CYCLES - 1));
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            rcnt  <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= (sync[1] == level || flip) ? '0 : cnt + DW'(1);
            level <= flip ? ~level : level;
            press <= (flip && !level) || rpt;
            rcnt  <= (flip || rpt || !level) ? '0 : rcnt + PW'(1);
        end
endmodule

// File: rtl/board_cursor_ctrl.sv
// board_cursor_ctrl: debounced cursor movement and select/confirm move-request handshake
module board_cursor_ctrl
    import chess_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES = 0,
    parameter int WRAP = 1,
    localparam int CW = $clog2(BOARD_W),
    localparam int RW = $clog2(BOARD_H)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          BTNU,
    input  logic          BTND,
    input  logic          BTNL,
    input  logic          BTNR,
    input  logic          BTNC,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          sel_valid,
    output logic [CW-1:0] sel_col,
    output logic [RW-1:0] sel_row,
    output logic          move_valid,
    output logic [CW-1:0] move_src_col,
    output logic [RW-1:0] move_src_row,
    output logic [CW-1:0] move_dst_col,
    output logic [RW-1:0] move_dst_row,
    input  logic          move_ready
);
    logic [NUM_BTN-1:0] raw, press, ev;
    state_t state;
    logic [CW-1:0] col_inc, col_dec, col_n;
    logic [RW-1:0] row_inc, row_dec, row_n;
    assign raw = {BTNC, BTNR, BTNL, BTND, BTNU};
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES(g == BTN_C ? 0 : REPEAT_CYCLES)
        ) u_db (
            .clk(clk),
            .reset(reset),
            .btn(raw[g]),
            .level(),
            .press(press[g])
        );
    end
    assign ev = (state == ST_REQUEST) ? '0 : press;
    assign row_inc = (cur_row == RW'(BOARD_H - 1)) ? (WRAP != 0 ? '0 : cur_row) : cur_row + RW'(1);
    assign row_dec = (cur_row == '0) ? (WRAP != 0 ? RW'(BOARD_H - 1) : cur_row) : cur_row - RW'(1);
    assign col_inc = (cur_col == CW'(BOARD_W - 1)) ? (WRAP != 0 ? '0 : cur_col) : cur_col + CW'(1);
    assign col_dec = (cur_col == '0) ? (WRAP != 0 ? CW'(BOARD_W - 1) : cur_col) : cur_col - CW'(1);
    // one direction per cycle, priority U > D > L > R
    assign row_n = ev[BTN_U] ? row_inc : ev[BTN_D] ? row_dec : cur_row;
    assign col_n = (ev[BTN_U] || ev[BTN_D]) ? cur_col : ev[BTN_L] ? col_dec : ev[BTN_R] ? col_inc : cur_col;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= ST_IDLE;
            cur_col      <= '0;
            cur_row      <= '0;
            sel_valid    <= 1'b0;
            sel_col      <= '0;
            sel_row      <= '0;
            move_valid   <= 1'b0;
            move_src_col <= '0;
            move_src_row <= '0;
            move_dst_col <= '0;
            move_dst_row <= '0;
        end else begin
            cur_col <= col_n;
            cur_row <= row_n;
            if (state == ST_IDLE && ev[BTN_C]) begin
                sel_col   <= cur_col;
                sel_row   <= cur_row;
                sel_valid <= 1'b1;
                state     <= ST_SELECTED;
            end else if (state == ST_SELECTED && ev[BTN_C]) begin
                if (cur_col == sel_col && cur_row == sel_row) begin
                    sel_valid <= 1'b0;
                    state     <= ST_IDLE;
                end else begin
                    move_src_col <= sel_col;
                    move_src_row <= sel_row;
                    move_dst_col <= cur_col;
                    move_dst_row <= cur_row;
                    move_valid   <= 1'b1;
                    state        <= ST_REQUEST;
                end
            end else if (state == ST_REQUEST && move_ready) begin
                move_valid <= 1'b0;
                sel_valid  <= 1'b0;
                state      <= ST_IDLE;
            end
        end
endmodule

// File: tb/tb_board_cursor_ctrl.sv
// tb_board_cursor_ctrl: scoreboard bench for wrap, saturate and auto-repeat cursor controllers
module tb_board_cursor_ctrl;
    import chess_pkg::*;
    logic clk = 1'b0, reset = 1'b0, move_ready = 1'b0;
    logic [4:0] btn = '0;
    logic [2:0] cur_col[3], cur_row[3], sel_col[3], sel_row[3];
    logic [2:0] src_col[3], src_row[3], dst_col[3], dst_row[3];
    logic sel_valid[3], move_valid[3];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        board_cursor_ctrl #(
            .BOARD_W(8), .BOARD_H(8), .DEBOUNCE_CYCLES(4),
            .REPEAT_CYCLES(g == 2 ? 10 : 0), .WRAP(g == 1 ? 0 : 1)
        ) dut (
            .clk(clk), .reset(reset),
            .BTNU(btn[BTN_U]), .BTND(btn[BTN_D]), .BTNL(btn[BTN_L]), .BTNR(btn[BTN_R]), .BTNC(btn[BTN_C]),
            .cur_col(cur_col[g]), .cur_row(cur_row[g]),
            .sel_valid(sel_valid[g]), .sel_col(sel_col[g]), .sel_row(sel_row[g]),
            .move_valid(move_valid[g]),
            .move_src_col(src_col[g]), .move_src_row(src_row[g]),
            .move_dst_col(dst_col[g]), .move_dst_row(dst_row[g]),
            .move_ready(move_ready)
        );
    end
    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    typedef struct {int c; int r;} pos_t;
    typedef struct {int sc; int sr; int dc; int dr;} mv_t;
    pos_t cq[$];
    mv_t mq[$];
    int ec = 0, er = 0, sc = 0, sr = 0, mv_rises = 0;
    bit has_sel = 0, req = 0;
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    // reference model for the wrapping 8x8 controller (instance 0)
    task automatic step(input int b);
        if (req) return;
        case (b)
            BTN_U: er = (er + 1) % 8;
            BTN_D: er = (er + 7) % 8;
            BTN_L: ec = (ec + 7) % 8;
            BTN_R: ec = (ec + 1) % 8;
            default: begin
                if (!has_sel) begin
                    has_sel = 1; sc = ec; sr = er;
                end else if (ec == sc && er == sr) has_sel = 0;
                else begin
                    mq.push_back('{sc, sr, ec, er});
                    req = 1;
                end
            end
        endcase
        if (b != BTN_C) cq.push_back('{ec, er});
    endtask
    task automatic press(input int b);
        step(b);
        btn[b] = 1'b1;
        cyc(10);
        btn[b] = 1'b0;
        cyc(8);
    endtask
    task automatic do_reset();
        reset = 1'b0; btn = '0; move_ready = 1'b0;
        cyc(3);
        ec = 0; er = 0; has_sel = 0; req = 0;
        cq.delete(); mq.delete();
        reset = 1'b1;
        cyc(1);
    endtask
    logic [2:0] pc = '0, pr = '0;
    logic pmv = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (cur_col[0] != pc || cur_row[0] != pr) begin
                if (cq.size() == 0) chk("cursor_unexpected", {cur_col[0], cur_row[0]}, {pc, pr});
                else begin
                    pos_t p;
                    p = cq.pop_front();
                    chk("cursor_col", cur_col[0], p.c);
                    chk("cursor_row", cur_row[0], p.r);
                end
            end
            if (move_valid[0] && !pmv) begin
                mv_rises++;
                if (mq.size() == 0) chk("move_unexpected", move_valid[0], 0);
                else begin
                    mv_t m;
                    m = mq.pop_front();
                    chk("move_src_col", src_col[0], m.sc);
                    chk("move_src_row", src_row[0], m.sr);
                    chk("move_dst_col", dst_col[0], m.dc);
                    chk("move_dst_row", dst_row[0], m.dr);
                end
            end
        end
        pc = cur_col[0]; pr = cur_row[0]; pmv = move_valid[0];
    end
    initial begin
        cyc(3);
        chk("rst_col", cur_col[0], 0);
        chk("rst_row", cur_row[0], 0);
        chk("rst_sel_valid", sel_valid[0], 0);
        chk("rst_move_valid", move_valid[0], 0);
        reset = 1'b1;
        cyc(1);
        step(BTN_U);
        btn[BTN_U] = 1'b1;
        cyc(6);
        chk("up_latency_6", cur_row[0], 0);
        cyc(1);
        chk("up_latency_7", cur_row[0], 1);
        cyc(3);
        btn[BTN_U] = 1'b0;
        cyc(10);
        chk("up_single_step", cur_row[0], 1);
        for (int i = 0; i < 5; i++) begin
            btn[BTN_R] = 1'b1; cyc(2);
            btn[BTN_R] = 1'b0; cyc(2);
        end
        chk("bounce_no_move", cur_col[0], 0);
        step(BTN_R);
        btn[BTN_R] = 1'b1;
        cyc(6);
        chk("bounce_hold_6", cur_col[0], 0);
        cyc(1);
        chk("bounce_hold_7", cur_col[0], 1);
        cyc(3);
        btn[BTN_R] = 1'b0;
        cyc(10);
        chk("bounce_single_step", cur_col[0], 1);
        do_reset();
        press(BTN_L);
        press(BTN_D);
        chk("wrap_col", cur_col[0], 7);
        chk("wrap_row", cur_row[0], 7);
        chk("sat_col", cur_col[1], 0);
        chk("sat_row", cur_row[1], 0);
        do_reset();
        repeat (4) press(BTN_R);
        press(BTN_U);
        press(BTN_C);
        chk("sel_valid", sel_valid[0], 1);
        chk("sel_col", sel_col[0], 4);
        chk("sel_row", sel_row[0], 1);
        press(BTN_U);
        press(BTN_U);
        press(BTN_C);
        for (int i = 0; i < 5; i++) begin
            chk("req_valid", move_valid[0], 1);
            chk("req_src_col", src_col[0], 4);
            chk("req_src_row", src_row[0], 1);
            chk("req_dst_col", dst_col[0], 4);
            chk("req_dst_row", dst_row[0], 3);
            cyc(1);
        end
        press(BTN_U);
        chk("req_frozen_row", cur_row[0], 3);
        chk("req_still_valid", move_valid[0], 1);
        move_ready = 1'b1;
        cyc(1);
        move_ready = 1'b0;
        req = 0; has_sel = 0;
        chk("ack_move_valid", move_valid[0], 0);
        chk("ack_sel_valid", sel_valid[0], 0);
        do_reset();
        press(BTN_R); press(BTN_R); press(BTN_U); press(BTN_U);
        press(BTN_C);
        chk("cancel_sel_set", sel_valid[0], 1);
        press(BTN_C);
        chk("cancel_sel_clr", sel_valid[0], 0);
        chk("cancel_no_move", mv_rises, 1);
        press(BTN_C);
        chk("cancel_back_idle", sel_valid[0], 1);
        do_reset();
        step(BTN_R);
        btn[BTN_R] = 1'b1;
        cyc(7);
        chk("rpt_first", cur_col[2], 1);
        cyc(9);
        chk("rpt_before_second", cur_col[2], 1);
        cyc(1);
        chk("rpt_second", cur_col[2], 2);
        cyc(21);
        chk("rpt_fourth", cur_col[2], 4);
        chk("norpt_single", cur_col[0], 1);
        reset = 1'b0;
        #1;
        chk("rst_async_col", cur_col[2], 0);
        chk("rst_async_row", cur_row[2], 0);
        chk("rst_async_sel", sel_valid[2], 0);
        chk("rst_async_mv", move_valid[2], 0);
        btn = '0;
        cq.delete();
        cyc(2);
        reset = 1'b1;
        cyc(2);
        chk("cursor_q_empty", cq.size(), 0);
        chk("move_q_empty", mq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
